// File: rtl/score_pkg.sv
// Shared types and helpers for the score accumulator: FSM state encoding,
// multiplier ceiling, BCD digit type and the 6-bit binary to 2-digit BCD converter.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_ADD,
        ST_COMMIT
    } state_t;

    localparam int unsigned MULT_MAX = 4;

    typedef logic [3:0] bcd_digit_t;

    // Compare-subtract against 10..60; input never exceeds 60.
    function automatic logic [7:0] bin6_to_bcd2(input logic [5:0] bin);
        bcd_digit_t tens;
        bcd_digit_t ones;
        tens = '0;
        for (int unsigned k = 1; k <= 6; k++) begin
            if (bin >= 6'(10 * k)) begin
                tens = 4'(k);
            end
        end
        ones = 4'(bin - 6'(tens) * 6'd10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit adder with carry: sum = a + b + cin, decimal-adjusted.
module bcd_digit_add (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_raw;

    assign w_raw = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

    // Results above 9 wrap by adding 6 and raise the decimal carry.
    always_comb begin
        o_sum  = w_raw[3:0];
        o_cout = 1'b0;
        if (w_raw > 5'd9) begin
            o_sum  = 4'(w_raw + 5'd6);
            o_cout = 1'b1;
        end
    end

endmodule

// File: rtl/score_accum.sv
// Combo-multiplied, digit-serial packed-BCD score accumulator.
// Build option: define SCORE_MAX_COMBO_EN to track the best combo of the game
// on max_combo; otherwise max_combo reads 0.
module score_accum
    import score_pkg::*;
#(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned COMBO_W   = 8,
    parameter int unsigned TIER_STEP = 10
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  clear,
    input  logic                  score_valid,
    input  logic [3:0]            score_in,
    input  logic                  miss,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [COMBO_W-1:0]    combo,
    output logic [2:0]            mult,
    output logic                  busy,
    output logic                  drop_err,
    output logic [COMBO_W-1:0]    max_combo
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4*DIGITS-1:0]  r_score;
    logic [4*DIGITS-1:0]  r_work;
    logic [7:0]           r_addsh;
    logic                 r_carry;
    logic [IDX_W-1:0]     r_idx;
    logic [5:0]           r_addend;
    logic [5:0]           r_pend;
    logic                 r_pend_v;
    logic                 r_drop;
    logic [COMBO_W-1:0]   r_combo;
    logic [COMBO_W-1:0]   w_combo_nxt;
    logic [COMBO_W-1:0]   w_tier;
    logic [2:0]           w_mult;
    logic [5:0]           w_addend;
    logic                 w_accept;
    logic                 w_busy;
    bcd_digit_t           w_sum;
    logic                 w_cout;

    assign w_accept = score_valid && !clear;
    assign w_busy   = (r_state != ST_IDLE);
    assign w_tier   = r_combo / COMBO_W'(TIER_STEP);
    assign w_addend = 6'(score_in) * 6'(w_mult);

    // Multiplier tier from the current combo, capped at MULT_MAX.
    always_comb begin
        w_mult = 3'(MULT_MAX);
        if (w_tier < COMBO_W'(MULT_MAX - 1)) begin
            w_mult = 3'(w_tier) + 3'd1;
        end
    end

    // Next combo: hits with points extend it (saturating), zero-point hits and misses break it.
    always_comb begin
        w_combo_nxt = r_combo;
        if (score_valid) begin
            if (score_in != 4'd0) begin
                w_combo_nxt = (r_combo == '1) ? r_combo : r_combo + COMBO_W'(1);
            end else begin
                w_combo_nxt = '0;
            end
        end
        if (miss) begin
            w_combo_nxt = '0;
        end
    end

    // The serial adder consumes the rotating working copy's low digit each ADD cycle.
    bcd_digit_add u_digit_add (
        .i_a    (r_work[3:0]),
        .i_b    (r_addsh[3:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: convert, add one digit per cycle, then commit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept || r_pend_v) w_state_nxt = ST_CONV;
            ST_CONV:   w_state_nxt = ST_ADD;
            ST_ADD:    if (r_idx == IDX_W'(DIGITS - 1)) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = r_pend_v ? ST_CONV : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Datapath: combo, addend/pending slot, serial BCD add and atomic score commit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_score  <= '0;
            r_work   <= '0;
            r_addsh  <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_addend <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_drop   <= 1'b0;
            r_combo  <= '0;
        end else if (clear) begin
            r_score  <= '0;
            r_work   <= '0;
            r_addsh  <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_addend <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_drop   <= 1'b0;
            r_combo  <= '0;
        end else begin
            r_combo <= w_combo_nxt;

            // A slot left filled during COMMIT is drained here while the new hit refills it.
            if (!w_busy) begin
                if (r_pend_v) begin
                    r_addend <= r_pend;
                    r_pend_v <= w_accept;
                    if (w_accept) begin
                        r_pend <= w_addend;
                    end
                end else if (w_accept) begin
                    r_addend <= w_addend;
                end
            end else begin
                if ((r_state == ST_COMMIT) && r_pend_v) begin
                    r_addend <= r_pend;
                    r_pend_v <= 1'b0;
                end
                if (w_accept) begin
                    if (r_pend_v) begin
                        r_drop <= 1'b1;
                    end else begin
                        r_pend   <= w_addend;
                        r_pend_v <= 1'b1;
                    end
                end
            end

            // Working copy rotates right one digit per ADD so the sum lands back in order.
            case (r_state)
                ST_CONV: begin
                    r_work  <= r_score;
                    r_addsh <= bin6_to_bcd2(r_addend);
                    r_carry <= 1'b0;
                    r_idx   <= '0;
                end
                ST_ADD: begin
                    r_work  <= {w_sum, r_work[4*DIGITS-1:4]};
                    r_addsh <= r_addsh >> 4;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                end
                ST_COMMIT: begin
                    r_score <= r_carry ? {DIGITS{4'h9}} : r_work;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SCORE_MAX_COMBO_EN
    logic [COMBO_W-1:0] r_max_combo;

    // Best combo of the current game.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_max_combo <= '0;
        end else if (clear) begin
            r_max_combo <= '0;
        end else if (w_combo_nxt > r_max_combo) begin
            r_max_combo <= w_combo_nxt;
        end
    end

    assign max_combo = r_max_combo;
`else
    assign max_combo = '0;
`endif

    assign score_bcd = r_score;
    assign combo     = r_combo;
    assign mult      = w_mult;
    assign busy      = w_busy;
    assign drop_err  = r_drop;

endmodule
